// File: rtl/mbe_final_adder_pipe.sv
// Two-stage carry-propagate adder closing the radix-4 MBE Dadda tree: sum + carry -> product mod 2^WIDTH.
// Optional registered zero flag (out_zero) when MBE_FINAL_ADD_ZERO_FLAG_EN is defined.
`timescale 1ns/1ps

module mbe_final_adder_pipe #(
   parameter int WIDTH = 22,
   parameter int SPLIT = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_product
`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
   ,
   output logic             out_zero
`endif
);

   localparam int HW = WIDTH - SPLIT;

   logic             s1_valid;
   logic [SPLIT-1:0] s1_lo;
   logic             s1_c_mid;
   logic [HW-1:0]    s1_sum_hi;
   logic [HW-1:0]    s1_carry_hi;
   logic             s2_valid;

   logic             s2_ready;
   logic             accept;
   logic             advance;
   logic [SPLIT:0]   lo_sum;
   logic [HW-1:0]    hi_sum;

   // Ready ripples backwards combinationally so a continuously-ready consumer sees no bubbles.
   assign s2_ready  = !s2_valid | out_ready;
   assign in_ready  = !s1_valid | s2_ready;
   assign accept    = in_valid & in_ready;
   assign advance   = s1_valid & s2_ready;
   assign out_valid = s2_valid;

   // Low chunk with one extra bit to capture the inter-chunk carry.
   assign lo_sum = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
   // Top carry-out is dropped; MBE sign-extension constants make the wrapped value correct.
   assign hi_sum = s1_sum_hi + s1_carry_hi + HW'(s1_c_mid);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept | (s1_valid & !advance);
      end
   end

   // NOTE: data registers are reset too, so out_product reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_lo       <= '0;
         s1_c_mid    <= 1'b0;
         s1_sum_hi   <= '0;
         s1_carry_hi <= '0;
      end else if (accept) begin
         s1_lo       <= lo_sum[SPLIT-1:0];
         s1_c_mid    <= lo_sum[SPLIT];
         s1_sum_hi   <= in_sum[WIDTH-1:SPLIT];
         s1_carry_hi <= in_carry[WIDTH-1:SPLIT];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= advance | (s2_valid & !out_ready);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_product <= '0;
      end else if (advance) begin
         out_product <= {hi_sum, s1_lo};
      end
   end

`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
   logic s1_lo_zero;

   // Zero detect is split like the adder: low chunk judged in stage 1, high chunk in stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_lo_zero <= 1'b0;
      end else if (accept) begin
         s1_lo_zero <= (lo_sum[SPLIT-1:0] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_zero <= 1'b0;
      end else if (advance) begin
         out_zero <= s1_lo_zero & (hi_sum == '0);
      end
   end
`endif

endmodule

// File: tb/tb_mbe_final_adder_pipe.sv
// Directed and random bench for mbe_final_adder_pipe with a queue scoreboard on the output handshake.
`timescale 1ns/1ps

module tb_mbe_final_adder_pipe;

   localparam int WIDTH = 22;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_product;
`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
   logic             out_zero;
`endif

   logic [WIDTH-1:0] sb[$];
   logic [WIDTH-1:0] exp_p;
   int               n_checks = 0;
   int               n_errors = 0;

   mbe_final_adder_pipe #(.WIDTH(WIDTH), .SPLIT(11)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_carry   (in_carry),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product)
`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
      ,
      .out_zero   (out_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // One isolated transfer into an empty pipe with out_ready high; checks 2-cycle latency.
   task automatic single(input string tag, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                         input logic [WIDTH-1:0] exp);
      in_sum   = s;
      in_carry = c;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_bit({tag, "_valid_c1"}, out_valid, 1'b0);
      @(posedge clk); #1;
      check_bit({tag, "_valid_c2"}, out_valid, 1'b1);
      check({tag, "_product"}, out_product, exp);
`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
      check_bit({tag, "_zero"}, out_zero, exp == '0);
`endif
   endtask

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_checks++;
            assert (sb.size() > 0) else begin
               n_errors++;
               $error("FAIL sb_unexpected_output: observed %0h expected no output", out_product);
            end
            if (sb.size() > 0) begin
               exp_p = sb.pop_front();
               check("sb_product", out_product, exp_p);
`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
               check_bit("sb_zero", out_zero, exp_p == '0);
`endif
            end
         end
         if (in_valid && in_ready) begin
            exp_p = in_sum + in_carry;
            sb.push_back(exp_p);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      out_ready = 1'b1;

      #12;
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b1);
      check("rst_product", out_product, '0);
`ifdef MBE_FINAL_ADD_ZERO_FLAG_EN
      check_bit("rst_zero", out_zero, 1'b0);
`endif
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      single("basic", 22'h000005, 22'h000003, 22'h000008);
      single("mid_carry", 22'h0007FF, 22'h000001, 22'h000800);
      single("wrap", 22'h3FFFFF, 22'h000002, 22'h000001);
      single("wrap_zero", 22'h3FFFFF, 22'h000001, 22'h000000);
      @(posedge clk); #1;

      // Back-pressure: two pairs fill the pipe, then the stall holds everything.
      out_ready = 1'b0;
      in_sum    = '0;
      in_carry  = 22'd1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_carry = 22'd2;
      @(posedge clk); #1;
      in_carry = 22'd3;
      check_bit("bp_in_ready_low", in_ready, 1'b0);
      check_bit("bp_out_valid", out_valid, 1'b1);
      check("bp_first_product", out_product, 22'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_stall_product", out_product, 22'd1);
         check_bit("bp_stall_in_ready", in_ready, 1'b0);
         check_bit("bp_stall_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_bit("bp_rel_valid2", out_valid, 1'b1);
      check("bp_rel_product2", out_product, 22'd2);
      in_carry = 22'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_bit("bp_rel_valid3", out_valid, 1'b1);
      check("bp_rel_product3", out_product, 22'd3);
      @(posedge clk); #1;
      check_bit("bp_rel_valid4", out_valid, 1'b1);
      check("bp_rel_product4", out_product, 22'd4);
      @(posedge clk); #1;
      check_bit("bp_drained", out_valid, 1'b0);

      // Full-throughput random stream.
      for (int i = 0; i < 1000; i++) begin
         in_sum   = WIDTH'($urandom);
         in_carry = WIDTH'($urandom);
         in_valid = 1'b1;
         check_bit("rand_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         if (i >= 1) check_bit("rand_out_valid", out_valid, 1'b1);
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_bit("rand_drained", out_valid, 1'b0);

      // Reset while two results are in flight.
      out_ready = 1'b0;
      in_sum    = 22'd1;
      in_carry  = 22'd1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_sum   = 22'd2;
      in_carry = 22'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_bit("pre_rst_full", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_bit("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_product", out_product, '0);
      check_bit("mid_rst_in_ready", in_ready, 1'b1);
      sb.delete();
      out_ready = 1'b1;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_bit("post_rst_idle", out_valid, 1'b0);
      single("post_rst", 22'h000010, 22'h000020, 22'h000030);
      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", WIDTH'(sb.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
